// File: rtl/freq_pkg.sv
// Shared constants for the frequency-pair sequencer: default word width and FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package freq_pkg;

  localparam int FREQ_W = 15;
  localparam int CNT_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_READ    = 3'd2,
    S_LATCH   = 3'd3,
    S_PRESENT = 3'd4,
    S_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/desync_timer.sv
// Counts WAIT cycles in which exactly one of the two FIFOs is empty; fires on the TIMEOUT-th such cycle.
// Latency: expired_o is combinational from the count register, asserted during the TIMEOUT-th one-sided cycle.
// Backpressure: none; the count clears whenever the FIFOs agree or the sequencer is not waiting.
module desync_timer
  import freq_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic ref_empty_i,
  input  logic song_empty_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             one_empty;

  assign one_empty = ref_empty_i ^ song_empty_i;
  assign expired_o = active_i && one_empty && (cnt_q == LAST);

  // next count: advance only while waiting on a lopsided FIFO pair, otherwise restart from zero
  always_comb begin
    cnt_d = '0;
    if (active_i && one_empty) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/freq_pair_sequencer.sv
// Pops ref/song FIFOs in lockstep and presents each frequency pair to the scorer; optional desync timeout (FREQ_SEQ_TIMEOUT_EN).
// Latency: both FIFOs non-empty in WAIT at t -> pair_valid at t+3; handshake at p -> WAIT at p+1.
// Backpressure: pair held stable while pair_ready is low; no further pops until the pair is accepted.
module freq_pair_sequencer #(
  parameter int NUM_PAIRS = 6,
  parameter int TIMEOUT   = 255,
  parameter int FREQ_W    = freq_pkg::FREQ_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ref_empty,
  input  logic              song_empty,
  input  logic [FREQ_W-1:0] ref_dout,
  input  logic [FREQ_W-1:0] song_dout,
  output logic              ref_rd_en,
  output logic              song_rd_en,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic [FREQ_W-1:0] pair_ref,
  output logic [FREQ_W-1:0] pair_song,
  output logic [7:0]        pair_count,
  output logic              busy,
  output logic              done,
  output logic              desync
);

  import freq_pkg::*;

  localparam logic [7:0] LAST_PAIR = 8'(NUM_PAIRS);

  state_e            state_q, state_d;
  logic [7:0]        count_q, count_d;
  logic [FREQ_W-1:0] ref_q, ref_d;
  logic [FREQ_W-1:0] song_q, song_d;
  logic              timeout_hit;

`ifdef FREQ_SEQ_TIMEOUT_EN
  logic desync_q, desync_d;

  desync_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_desync_timer (
    .clk         (clk),
    .rst         (rst),
    .active_i    (state_q == S_WAIT),
    .ref_empty_i (ref_empty),
    .song_empty_i(song_empty),
    .expired_o   (timeout_hit)
  );

  // desync is sticky for the rest of the session; a fresh start clears it
  always_comb begin
    desync_d = desync_q;
    if (state_q == S_IDLE && start) begin
      desync_d = 1'b0;
    end else if (timeout_hit) begin
      desync_d = 1'b1;
    end
  end

  // desync flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      desync_q <= 1'b0;
    end else begin
      desync_q <= desync_d;
    end
  end

  assign desync = desync_q;
`else
  assign timeout_hit = 1'b0;
  assign desync      = 1'b0;
`endif

  // next-state and datapath: one pop per pair, capture the data the cycle after the pop
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ref_d   = ref_q;
    song_d  = song_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT;
          count_d = '0;
        end
      end
      S_WAIT: begin
        if (timeout_hit) begin
          state_d = S_DONE;
        end else if (!ref_empty && !song_empty) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        ref_d   = ref_dout;
        song_d  = song_dout;
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (pair_ready) begin
          if (count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
          end
          state_d = (count_d == LAST_PAIR) ? S_DONE : S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state, count and presented-pair registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      ref_q   <= '0;
      song_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ref_q   <= ref_d;
      song_q  <= song_d;
    end
  end

  assign ref_rd_en  = (state_q == S_READ);
  assign song_rd_en = (state_q == S_READ);
  assign pair_valid = (state_q == S_PRESENT);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign pair_ref   = ref_q;
  assign pair_song  = song_q;
  assign pair_count = count_q;

endmodule

// File: tb/tb_freq_pair_sequencer.sv
// Randomized and directed bench for freq_pair_sequencer with behavioural FIFO and pair-order model.
// Latency: expectations are derived from cycle counts relative to the start pulse and each handshake.
// Backpressure: pair_ready is stalled directly and randomly to exercise hold behaviour.
module tb_freq_pair_sequencer;

  localparam int FW = 15;
  localparam int NP = 6;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          ref_empty, song_empty;
  logic [FW-1:0] ref_dout = '0;
  logic [FW-1:0] song_dout = '0;
  logic          ref_rd_en, song_rd_en;
  logic          pair_valid, pair_ready;
  logic [FW-1:0] pair_ref, pair_song;
  logic [7:0]    pair_count;
  logic          busy, done, desync;

  int total = 0;
  int bad   = 0;

  freq_pair_sequencer #(
    .NUM_PAIRS(NP),
    .TIMEOUT  (TO),
    .FREQ_W   (FW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ref_empty (ref_empty),
    .song_empty(song_empty),
    .ref_dout  (ref_dout),
    .song_dout (song_dout),
    .ref_rd_en (ref_rd_en),
    .song_rd_en(song_rd_en),
    .pair_valid(pair_valid),
    .pair_ready(pair_ready),
    .pair_ref  (pair_ref),
    .pair_song (pair_song),
    .pair_count(pair_count),
    .busy      (busy),
    .done      (done),
    .desync    (desync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // behavioural non-FWFT FIFOs: data appears on dout the cycle after the pop strobe
  logic [FW-1:0] rmem [0:255];
  logic [FW-1:0] smem [0:255];
  int r_wr = 0, r_rd = 0, s_wr = 0, s_rd = 0;
  int r_pops = 0, s_pops = 0, underflow = 0;

  assign ref_empty  = (r_wr == r_rd);
  assign song_empty = (s_wr == s_rd);

  always @(posedge clk) begin
    if (ref_rd_en) begin
      r_pops <= r_pops + 1;
      if (r_wr != r_rd) begin
        ref_dout <= rmem[r_rd % 256];
        r_rd     <= r_rd + 1;
      end else begin
        underflow <= underflow + 1;
      end
    end
    if (song_rd_en) begin
      s_pops <= s_pops + 1;
      if (s_wr != s_rd) begin
        song_dout <= smem[s_rd % 256];
        s_rd      <= s_rd + 1;
      end else begin
        underflow <= underflow + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    r_wr = r_rd;
    s_wr = s_rd;
  endtask

  // session plan: pair values and the sample index at which each is pushed
  logic [FW-1:0] sv_r [NP];
  logic [FW-1:0] sv_s [NP];
  int            pt_r [NP];
  int            pt_s [NP];

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, pair_valid, 0);
    chk({tag, "_rd"}, {ref_rd_en, song_rd_en}, 0);
    chk({tag, "_count"}, pair_count, 0);
    chk({tag, "_ref"}, pair_ref, 0);
    chk({tag, "_song"}, pair_song, 0);
    chk({tag, "_desync"}, desync, 0);
  endtask

  // Runs one session. Pair k presented must equal pair k pushed; returns early when abort_hs pairs are accepted.
  task automatic run_session(input string tag, input int stall_idx, input bit rand_ready,
                             input bit hold_start, input bit check_lat, input int abort_hs);
    int hs = 0, first_valid = -1, last_hs = -1, done_cnt = 0, done_at = -1;
    int nr = 0, ns = 0, stall_left = 10, rb = r_pops, sb = s_pops, rp_prev = 0;
    logic pv_prev = 1'b0, hs_prev = 1'b0;
    logic [FW-1:0] pr_prev = '0, ps_prev = '0;
    bit aborted = 1'b0;
    for (int k = 0; k < 600; k++) begin
      while (nr < NP && pt_r[nr] <= k) begin
        rmem[r_wr % 256] = sv_r[nr]; r_wr++; nr++;
      end
      while (ns < NP && pt_s[ns] <= k) begin
        smem[s_wr % 256] = sv_s[ns]; s_wr++; ns++;
      end
      start = hold_start ? (done_at < 0 || k <= done_at) : (k == 0);
      if (abort_hs >= 0 && hs == abort_hs && pair_valid) begin
        aborted = 1'b1;
        break;
      end
      if (stall_idx == hs && pair_valid && stall_left > 0) begin
        pair_ready = 1'b0;
        stall_left--;
      end else begin
        pair_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (pv_prev && !hs_prev && pair_valid) begin
        chk({tag, "_hold_ref"}, pair_ref, pr_prev);
        chk({tag, "_hold_song"}, pair_song, ps_prev);
        chk({tag, "_hold_nopop"}, r_pops, rp_prev);
      end
      if (hs_prev) chk({tag, "_count_step"}, pair_count, hs);
      if (done_at >= 0 && k == done_at + 1) chk({tag, "_idle_after_done"}, busy, 0);
      if (pair_valid && first_valid < 0) first_valid = k;
      if (pair_valid && pair_ready) begin
        if (hs < NP) begin
          chk({tag, "_pair_ref"}, pair_ref, sv_r[hs]);
          chk({tag, "_pair_song"}, pair_song, sv_s[hs]);
        end else begin
          chk({tag, "_extra_pair"}, hs, NP - 1);
        end
        if (check_lat && last_hs >= 0) chk({tag, "_hs_to_valid"}, k - last_hs, 4);
        last_hs = k;
        hs++;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      pv_prev = pair_valid;
      hs_prev = pair_valid && pair_ready;
      pr_prev = pair_ref;
      ps_prev = pair_song;
      rp_prev = r_pops;
      if (done_at >= 0 && k == done_at + 2) break;
      tick();
    end
    if (!aborted) begin
      chk({tag, "_done_pulses"}, done_cnt, 1);
      chk({tag, "_pairs"}, hs, NP);
      chk({tag, "_final_count"}, pair_count, NP);
      chk({tag, "_ref_pops"}, r_pops - rb, NP);
      chk({tag, "_song_pops"}, s_pops - sb, NP);
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_desync"}, desync, 0);
      if (check_lat) chk({tag, "_start_to_valid"}, first_valid, 4);
    end else begin
      chk({tag, "_abort_count"}, pair_count, abort_hs);
    end
    start = 1'b0;
    pair_ready = 1'b0;
  endtask

  task automatic plan_spec_preload();
    logic [FW-1:0] songs [NP];
    songs = '{15'd440, 15'd329, 15'd390, 15'd448, 15'd462, 15'd466};
    for (int i = 0; i < NP; i++) begin
      sv_r[i] = 15'd440;
      sv_s[i] = songs[i];
      pt_r[i] = 0;
      pt_s[i] = 0;
    end
  endtask

  task automatic plan_random();
    int base = 0;
    for (int i = 0; i < NP; i++) begin
      base += $urandom_range(4, 8);
      sv_r[i] = FW'($urandom_range(0, 32767));
      sv_s[i] = FW'($urandom_range(0, 32767));
      pt_r[i] = base;
      pt_s[i] = base + $urandom_range(0, 3);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    flush();
  endtask

  initial begin
    int done_at;
    int rb;
    rst = 1'b1;
    start = 1'b0;
    pair_ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // preloaded reference session, always ready: order, latency, count, single done
    plan_spec_preload();
    run_session("spec", -1, 1'b0, 1'b0, 1'b1, -1);

    // 10-cycle stall on the 440/329 pair
    plan_spec_preload();
    run_session("stall", 1, 1'b0, 1'b0, 1'b0, -1);

    // start held high through the session and the DONE cycle
    plan_spec_preload();
    run_session("hold_start", -1, 1'b0, 1'b1, 1'b0, -1);

    // reset in PRESENT after three pairs; reset beats start and pair_ready
    plan_spec_preload();
    run_session("pre_rst", -1, 1'b0, 1'b0, 1'b0, 3);
    rst = 1'b1;
    start = 1'b1;
    pair_ready = 1'b1;
    tick();
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    start = 1'b0;
    pair_ready = 1'b0;
    flush();
    tick();
    plan_spec_preload();
    run_session("restart", -1, 1'b0, 1'b0, 1'b1, -1);

    // randomized values, push timing and backpressure
    for (int s = 0; s < 4; s++) begin
      plan_random();
      run_session("rand", -1, 1'b1, (s % 2) == 1, 1'b0, -1);
    end

    // lopsided FIFOs: one ref entry, song empty
    do_reset();
    tick();
    rmem[r_wr % 256] = 15'd440;
    r_wr++;
    rb = r_pops;
    done_at = -1;
    start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k == 1) start = 1'b0;
      if (done && done_at < 0) done_at = k;
      tick();
    end
`ifdef FREQ_SEQ_TIMEOUT_EN
    chk("timeout_done_at", done_at, 21);
    chk("timeout_desync", desync, 1);
    chk("timeout_busy", busy, 0);
`else
    chk("timeout_done_at", done_at, -1);
    chk("timeout_desync", desync, 0);
    chk("timeout_busy", busy, 1);
`endif
    chk("timeout_no_pop", r_pops - rb, 0);
    do_reset();
    chk("underflow", underflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/freq_pair_sequencer.md
FREQ_PAIR_SEQUENCER -- requirements
Module: freq_pair_sequencer

Interface
REQ-001 Parameter NUM_PAIRS, default 6: number of ref/song pairs per scoring session (legal 1..255).
REQ-002 Parameter TIMEOUT, default 255: desync timeout in cycles (legal 1..255).
REQ-003 Parameter FREQ_W, default 15: frequency word width.
REQ-004 clk  in  1  sole clock; all logic on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  begin session; sampled only in IDLE.
REQ-007 ref_empty / song_empty  in  1 each  reference / song FIFO empty flags.
REQ-008 ref_dout / song_dout  in  FREQ_W each  FIFO read data, valid one cycle after rd_en (standard, non-FWFT).
REQ-009 ref_rd_en / song_rd_en  out  1 each  FIFO pop strobes.
REQ-010 pair_valid  out  1; pair_ready  in  1: handshake to the scoring unit.
REQ-011 pair_ref / pair_song  out  FREQ_W each  presented frequency pair.
REQ-012 pair_count  out  8  pairs accepted this session.
REQ-013 busy  out  1 (not IDLE); done  out  1 (one-cycle end-of-session pulse); desync  out  1 (sticky timeout flag).

Function
REQ-014 FSM states IDLE, WAIT, READ, LATCH, PRESENT, DONE; all outputs registered or decoded from state only.
REQ-015 IDLE: start=1 -> WAIT, clear pair_count and desync; start ignored in any other state.
REQ-016 WAIT: ref_empty=0 and song_empty=0 in the same cycle -> READ; otherwise stay.
REQ-017 READ lasts exactly one cycle with ref_rd_en=song_rd_en=1; both strobes are 0 in every other state, so FIFOs always pop together.
REQ-018 LATCH: capture ref_dout/song_dout into pair_ref/pair_song at end of cycle -> PRESENT.
REQ-019 PRESENT: pair_valid=1, pair_ref/pair_song held stable until pair_valid and pair_ready both 1.
REQ-020 On handshake: pair_count increments; if new count equals NUM_PAIRS -> DONE, else -> WAIT.
REQ-021 Latency: both FIFOs non-empty in WAIT at cycle t gives pair_valid=1 at t+3; handshake at cycle p gives WAIT at p+1.
REQ-022 DONE: done=1 for exactly one cycle -> IDLE; pair_count and desync hold until next start.
REQ-023 pair_ready while not PRESENT is ignored; pair_count saturates at 255 and never wraps.

Reset
REQ-024 rst=1 at any cycle, including mid-session: state IDLE; rd_en, pair_valid, done, busy, desync = 0; pair_count=0; pair_ref/pair_song=0; timeout counter=0.
REQ-025 rst takes priority over start and pair_ready in the same cycle.

Configuration
REQ-026 Macro FREQ_SEQ_TIMEOUT_EN defined: in WAIT an 8-bit counter increments each cycle exactly one FIFO is empty, clears when both are empty, both non-empty, or on leaving WAIT; on reaching TIMEOUT set desync=1 and go to DONE.
REQ-027 Macro undefined: no timeout counter, desync tied 0, WAIT waits indefinitely.

Structure
REQ-028 Shared package freq_pkg holds FREQ_W and the state encoding constants.
REQ-029 Timeout counter is sub-module desync_timer, instantiated only under FREQ_SEQ_TIMEOUT_EN.

Verification
REQ-030 Both FIFOs preloaded with 6 pairs (440/440, 440/329, 440/390, 440/448, 440/462, 440/466), pair_ready=1, start pulse -> six pairs in order, pair_count=6, single done pulse, 6 pops per FIFO.
REQ-031 pair_ready=0 for 10 cycles in PRESENT -> pair_valid and pair_ref=440/pair_song=329 held stable, no extra pop.
REQ-032 Ref FIFO holds 1 entry, song FIFO empty, TIMEOUT=20, macro defined -> desync=1 and done 20 cycles after WAIT entry, no rd_en; macro undefined -> stays in WAIT, desync=0.
REQ-033 rst asserted in PRESENT after 3 pairs -> next cycle all outputs at reset values; new start restarts at pair_count=0.
REQ-034 start held high during a session and asserted in DONE cycle -> ignored; a new session begins only on start seen in IDLE.
